// File: rtl/stream_demux_if.sv
// stream_demux_if: single-source stream in, N_CH registered streams out
interface stream_demux_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
);
  logic                  s_valid;
  logic                  s_ready;
  logic [WIDTH-1:0]      s_data;
  logic [SEL_W-1:0]      s_sel;
  logic                  s_last;
  logic [N_CH-1:0]       m_valid;
  logic [N_CH-1:0]       m_ready;
  logic [N_CH*WIDTH-1:0] m_data;
  logic [N_CH-1:0]       m_last;
  modport slave (input s_valid, s_data, s_sel, s_last, m_ready,
                 output s_ready, m_valid, m_data, m_last);
  modport master (output s_valid, s_data, s_sel, s_last, m_ready,
                  input s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/stream_demux.sv
// stream_demux: registered 1:N_CH stream demux with packet locking and drop counting
module stream_demux #(
  parameter int WIDTH       = 8,
  parameter int N_CH        = 4,
  parameter int SEL_W       = $clog2(N_CH),
  parameter int PACKET_MODE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_demux_if.slave  bus,
  output logic           busy,
  output logic [7:0]     drop_cnt
);
  typedef enum logic [1:0] {IDLE, LOCK, DROP} state_t;
  localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_CH);
  state_t                state, state_nx;
  logic [SEL_W-1:0]      lock_ch, target;
  logic                  tgt_ok, tgt_free, rdy, accept, load, drop;
  logic [N_CH-1:0]       vld, lst, free;
  logic [N_CH*WIDTH-1:0] dat;
  assign bus.s_ready = rdy;
  assign bus.m_valid = vld;
  assign bus.m_last  = lst;
  assign bus.m_data  = dat;
  assign busy        = state != IDLE;
  // Target selection, source back-pressure and next FSM state
  always_comb begin
    target   = (PACKET_MODE != 0 && state == LOCK) ? lock_ch : bus.s_sel;
    tgt_ok   = {1'b0, target} < N_LIM;
    free     = ~vld | bus.m_ready;
    tgt_free = 1'b0;
    for (int k = 0; k < N_CH; k++) tgt_free = (target == SEL_W'(k)) ? free[k] : tgt_free;
    rdy      = (state == DROP || !tgt_ok) ? 1'b1 : tgt_free;
    accept   = bus.s_valid && rdy;
    load     = accept && tgt_ok && state != DROP;
    drop     = accept && !load;
    state_nx = (PACKET_MODE == 0 || !accept) ? state :
               (state == IDLE) ? (bus.s_last ? IDLE : tgt_ok ? LOCK : DROP) :
               (bus.s_last ? IDLE : state);
  end
  // Per-channel output registers: load on accepted beat, clear valid on drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      lst <= '0;
      dat <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (load && target == SEL_W'(k)) begin
          vld[k]                <= 1'b1;
          lst[k]                <= bus.s_last;
          dat[k*WIDTH +: WIDTH] <= bus.s_data;
        end else if (bus.m_ready[k]) begin
          vld[k] <= 1'b0;
        end
      end
    end
  end
  // FSM state, locked channel and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_ch  <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nx;
      lock_ch  <= (state == IDLE && load) ? target : lock_ch;
      drop_cnt <= (drop && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
    end
  end
endmodule
